// File: rtl/board_if.sv
// board_if: request/response bundle between the game control FSM and the board datapath
interface board_if;
  logic       start;
  logic [7:0] seed;
  logic       req;
  logic [3:0] card;
  logic       ready;
  logic       resp_valid;
  logic       go;
  logic       win;
  logic [3:0] pos;
  logic [3:0] steps;
  modport master (output start, seed, req, card, input ready, resp_valid, go, win, pos, steps);
  modport slave  (input start, seed, req, card, output ready, resp_valid, go, win, pos, steps);
endinterface

// File: rtl/board_datapath.sv
// board_datapath: LFSR-filled ring track, card/tile match and chicken advance for Chicken Cha-Cha-Cha
module board_datapath #(
  parameter int TRACK_LEN = 12,
  parameter int GOAL      = 8
) (
  input logic   clk,
  input logic   rst,
  board_if.slave bus
);
  typedef enum logic [2:0] {EMPTY, INIT, IDLE, EVAL, RESP, WON} state_t;
  state_t     state_q, state_d;
  logic [7:0] lfsr_q;
  logic [3:0] i_q, card_q, pos_q, steps_q, nxt, raw;
  logic       go_q, win_q, match, last_init;
  logic [3:0] tile_q [16];
  // tile lookup ahead of the chicken and end-of-fill detection
  always_comb begin
    nxt       = ({1'b0, pos_q} + 5'd1 == 5'(TRACK_LEN)) ? 4'd0 : pos_q + 4'd1;
    match     = (card_q < 4'd12) && (card_q == tile_q[nxt]);
    last_init = {1'b0, i_q} == 5'(TRACK_LEN - 1);
    raw       = lfsr_q[3:0];
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  // next state; start overrides everything, EMPTY and WON wait for it
  always_comb begin
    state_d = bus.start          ? INIT :
              state_q == INIT    ? (last_init ? IDLE : INIT) :
              state_q == IDLE    ? (bus.req ? EVAL : IDLE) :
              state_q == EVAL    ? RESP :
              state_q == RESP    ? (win_q ? WON : IDLE) : state_q;
  end
  // handshake outputs decoded from state, board status from registers
  always_comb begin
    bus.ready      = state_q == IDLE;
    bus.resp_valid = state_q == RESP;
    bus.go         = go_q;
    bus.win        = win_q;
    bus.pos        = pos_q;
    bus.steps      = steps_q;
  end
  // LFSR, fill counter, latched card and move results (visible in RESP)
  always_ff @(posedge clk)
    if (rst) begin
      lfsr_q  <= 8'h01;
      i_q     <= '0;
      card_q  <= '0;
      pos_q   <= '0;
      steps_q <= '0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else if (bus.start) begin
      lfsr_q  <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
      i_q     <= '0;
      pos_q   <= '0;
      steps_q <= '0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        i_q    <= i_q + 4'd1;
      end
      if (state_q == IDLE && bus.req) card_q <= bus.card;
      if (state_q == EVAL) begin
        go_q <= match;
        if (match) begin
          pos_q   <= nxt;
          steps_q <= steps_q + 4'd1;
          win_q   <= steps_q + 4'd1 == 4'(GOAL);
        end
      end
    end
  // tile memory, written only while filling
  always_ff @(posedge clk)
    if (state_q == INIT) tile_q[i_q] <= (raw < 4'd12) ? raw : raw - 4'd12;
endmodule

// File: tb/tb_board_datapath.sv
// tb_board_datapath: directed plus randomized checks of two board sizes against a rule-level model
module tb_board_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0, req = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] card = '0;
  logic o_ready, o_rv, o_go, o_win;
  logic [3:0] o_pos, o_steps;
  int checks = 0, errors = 0;
  int tl = 12, goal = 8;
  int m_tiles [16];
  int m_pos = 0, m_steps = 0;
  logic m_win = 1'b0, m_go = 1'b0;

  board_if ia ();
  board_if ib ();
  board_datapath #(.TRACK_LEN(12), .GOAL(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  board_datapath #(.TRACK_LEN(4),  .GOAL(5)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  assign ia.start = start & ~sel;
  assign ia.req   = req & ~sel;
  assign ia.seed  = seed;
  assign ia.card  = card;
  assign ib.start = start & sel;
  assign ib.req   = req & sel;
  assign ib.seed  = seed;
  assign ib.card  = card;
  assign o_ready  = sel ? ib.ready : ia.ready;
  assign o_rv     = sel ? ib.resp_valid : ia.resp_valid;
  assign o_go     = sel ? ib.go : ia.go;
  assign o_win    = sel ? ib.win : ia.win;
  assign o_pos    = sel ? ib.pos : ia.pos;
  assign o_steps  = sel ? ib.steps : ia.steps;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_go"}, o_go, m_go);
    chk({tag, "_win"}, o_win, m_win);
    chk({tag, "_pos"}, o_pos, 8'(m_pos));
    chk({tag, "_steps"}, o_steps, 8'(m_steps));
  endtask

  // tiles from the seeding rule: low nibble folded into 0..11, then shift in the tap parity
  task automatic model_init(input logic [7:0] s);
    int l, v, fb;
    l = (s == 0) ? 1 : s;
    for (int k = 0; k < tl; k++) begin
      v = l % 16;
      m_tiles[k] = (v < 12) ? v : v - 12;
      fb = ((l >> 7) + (l >> 5) + (l >> 4) + (l >> 3)) % 2;
      l = (l * 2 + fb) % 256;
    end
    m_pos = 0; m_steps = 0; m_win = 1'b0; m_go = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] s, input string tag);
    int n;
    logic seen_rv;
    start = 1'b1; seed = s;
    model_init(s);
    tick;
    start = 1'b0;
    n = 0; seen_rv = 1'b0;
    while (!o_ready && n < 40) begin
      seen_rv |= o_rv;
      tick;
      n++;
    end
    chk({tag, "_init_cycles"}, 8'(n), 8'(tl));
    chk({tag, "_init_rv"}, seen_rv, 1'b0);
    chk_status({tag, "_init"});
  endtask

  task automatic pick(input logic [3:0] c, input string tag);
    int nx;
    logic match;
    chk({tag, "_rdy_t0"}, o_ready, 1'b1);
    req = 1'b1; card = c;
    tick;
    req = 1'b0;
    nx = (m_pos + 1) % tl;
    match = (c < 12) && (int'(c) == m_tiles[nx]);
    m_go = match;
    if (match) begin
      m_pos = nx;
      m_steps++;
      if (m_steps == goal) m_win = 1'b1;
    end
    chk({tag, "_rdy_t1"}, o_ready, 1'b0);
    chk({tag, "_rv_t1"}, o_rv, 1'b0);
    tick;
    chk({tag, "_rv_t2"}, o_rv, 1'b1);
    chk_status({tag, "_t2"});
    tick;
    chk({tag, "_rv_t3"}, o_rv, 1'b0);
    chk({tag, "_rdy_t3"}, o_ready, !m_win);
  endtask

  task automatic dropped_reqs(input string tag);
    logic seen;
    seen = 1'b0;
    req = 1'b1; card = 4'(m_tiles[(m_pos + 1) % tl]);
    for (int k = 0; k < 4; k++) begin
      tick;
      seen |= o_rv | o_ready;
    end
    req = 1'b0;
    chk({tag, "_ignored"}, seen, 1'b0);
    chk_status({tag, "_held"});
  endtask

  task automatic rand_picks(input int n, input string tag);
    logic [3:0] c;
    for (int k = 0; k < n && !m_win; k++) begin
      c = $urandom_range(0, 1) ? 4'(m_tiles[(m_pos + 1) % tl]) : 4'($urandom_range(0, 15));
      pick(c, tag);
    end
  endtask

  initial begin
    tick; tick;
    chk("rst_ready", o_ready, 1'b0);
    chk_status("rst");
    rst = 1'b0;
    req = 1'b1; card = 4'd1;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick;
        seen |= o_rv | o_ready;
      end
      chk("empty_req_ignored", seen, 1'b0);
    end
    req = 1'b0;

    sel = 1'b0; tl = 12; goal = 8;
    do_start(8'h01, "a_seed1");
    pick(4'd2, "a_match");
    chk("a_first_pos", o_pos, 8'd1);
    pick(4'd5, "a_mismatch");
    pick(4'd14, "a_invalid");
    chk("a_hold_pos", o_pos, 8'd1);
    rand_picks(60, "a_rand");
    if (m_win) dropped_reqs("a_won");

    do_start(8'h00, "a_seed0");
    pick(4'd2, "a_seed0_match");
    chk("a_seed0_go", o_go, 1'b1);

    pick(4'(m_tiles[(m_pos + 1) % tl]), "a_pre_eval");
    req = 1'b1; card = 4'(m_tiles[(m_pos + 1) % tl]);
    tick;
    req = 1'b0;
    do_start(8'($urandom_range(0, 255)), "a_start_eval");
    rand_picks(30, "a_rand2");

    start = 1'b1; seed = 8'h5a;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_pos = 0; m_steps = 0; m_win = 1'b0; m_go = 1'b0;
    chk("mid_init_rst_ready", o_ready, 1'b0);
    chk_status("mid_init_rst");
    tick; tick;
    chk("after_rst_empty", o_ready, 1'b0);

    sel = 1'b1; tl = 4; goal = 5;
    do_start(8'h01, "b_seed1");
    pick(4'd2, "b_w1");
    pick(4'd4, "b_w2");
    pick(4'd8, "b_w3");
    pick(4'd1, "b_wrap");
    chk("b_wrap_pos", o_pos, 8'd0);
    pick(4'd2, "b_w5");
    chk("b_win", o_win, 1'b1);
    dropped_reqs("b_won");
    for (int r = 0; r < 3; r++) begin
      do_start(8'($urandom_range(0, 255)), "b_rseed");
      rand_picks(25, "b_rand");
      if (m_win) dropped_reqs("b_rwon");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
